// File: rtl/wb_dma_ram_pkg.sv
// Shared constants and helpers for the multi-channel Wishbone/DMA RAM.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package wb_dma_ram_pkg;

   localparam int MEM_WORD_BITS = 32;

   // Width of a channel index; never below one bit so single-channel builds still have a vector.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, search starts at the pointer.
// Latency: grant is combinational from req and the pointer; the pointer updates on the next edge.
// Backpressure: none; an ungranted requester simply waits. Grant is forced low during reset.
module rr_arbiter
   import wb_dma_ram_pkg::*;
#(
   parameter int NUM_CHANNELS = 2
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst_n,
   input  logic [NUM_CHANNELS-1:0] req,
   output logic [NUM_CHANNELS-1:0] gnt
);

   localparam int CW = ch_idx_w(NUM_CHANNELS);

   logic [CW-1:0] ptr;
   logic [CW-1:0] gnt_idx;
   logic [CW-1:0] idx_c;
   logic          found;
   int            idx;

   // Search from the pointer, wrapping once round the channels; first requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx_c   = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         idx_c = CW'(idx);
         if (!found && req[idx_c] && wb_rst_n) begin
            found        = 1'b1;
            gnt[idx_c]   = 1'b1;
            gnt_idx      = idx_c;
         end
      end
   end

   // Pointer moves to the channel after the winner; holds when nothing is granted.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gnt_idx == CW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/wb_dma_ram_mch.sv
// Dual-port RAM shared by a Wishbone slave and NUM_CHANNELS round-robin DMA channels.
// Latency: ack/err/vld 1 cycle after the access (2 with WB_DMA_RAM_MCH_OUTREG_EN defined).
// Backpressure: WB waits for ack/err (one access per 2, or 3, cycles); channels wait for grant.
module wb_dma_ram_mch
   import wb_dma_ram_pkg::*;
#(
   parameter int NUM_CHANNELS  = 2,
   parameter int DEPTH_WORDS   = 2048,
   parameter int WB_ADDR_WIDTH = $clog2(DEPTH_WORDS * 4) + 1
) (
   input  logic                                    wb_clk,
   input  logic                                    wb_rst_n,
   input  logic [WB_ADDR_WIDTH-1:0]                wb_adr_i,
   input  logic [31:0]                             wb_dat_i,
   output logic [31:0]                             wb_dat_o,
   input  logic                                    wb_we_i,
   input  logic [3:0]                              wb_sel_i,
   input  logic                                    wb_stb_i,
   input  logic                                    wb_cyc_i,
   output logic                                    wb_ack_o,
   output logic                                    wb_err_o,
   input  logic [NUM_CHANNELS-1:0]                 ch_req_i,
   input  logic [NUM_CHANNELS-1:0]                 ch_we_i,
   input  logic [NUM_CHANNELS*(WB_ADDR_WIDTH-2)-1:0] ch_adr_i,
   input  logic [NUM_CHANNELS*32-1:0]              ch_dat_i,
   output logic [NUM_CHANNELS-1:0]                 ch_gnt_o,
   output logic [NUM_CHANNELS-1:0]                 ch_vld_o,
   output logic [31:0]                             ch_dat_o,
   output logic                                    coll_o
);

   localparam int AWW = $clog2(DEPTH_WORDS);
   localparam int CAW = WB_ADDR_WIDTH - 2;
   localparam logic [CAW-1:0] DEPTH_LIM = CAW'(DEPTH_WORDS);

   logic [MEM_WORD_BITS-1:0] mem [DEPTH_WORDS];

   // Wishbone side decode.
   logic [CAW-1:0]           wb_word;
   logic [AWW-1:0]           wb_ridx;
   logic                     wb_in_rng;
   logic                     wb_pend;
   logic                     wb_acc;
   logic                     wb_wr;
   logic [3:0]               sel_q;
   logic                     ack_s1;
   logic                     err_s1;
   logic [MEM_WORD_BITS-1:0] ram_q_a;
   logic [MEM_WORD_BITS-1:0] wb_rd_masked;

   // Channel side decode.
   logic                     ch_any;
   logic [AWW-1:0]           ch_word;
   logic [MEM_WORD_BITS-1:0] ch_wdat;
   logic                     ch_wsel;
   logic                     ch_wr;
   logic [NUM_CHANNELS-1:0]  ch_rd_vec;
   logic [NUM_CHANNELS-1:0]  vld_s1;
   logic [MEM_WORD_BITS-1:0] ram_q_b;

   // Byte-lane bits and the spare channel address bits are deliberately ignored.
   logic unused_adr;
   assign unused_adr = ^{wb_adr_i[1:0], ch_adr_i};

   assign wb_word   = wb_adr_i[WB_ADDR_WIDTH-1:2];
   assign wb_ridx   = wb_word[AWW-1:0];
   assign wb_in_rng = (wb_word < DEPTH_LIM);
   assign wb_acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o & ~wb_pend & wb_rst_n;
   assign wb_wr     = wb_acc & wb_in_rng & wb_we_i;

   rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_arb (
      .wb_clk   (wb_clk),
      .wb_rst_n (wb_rst_n),
      .req      (ch_req_i),
      .gnt      (ch_gnt_o)
   );

   // Route the granted channel's address, data and direction to memory port B.
   always_comb begin
      ch_any  = 1'b0;
      ch_word = '0;
      ch_wdat = '0;
      ch_wsel = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         if (ch_gnt_o[k]) begin
            ch_any  = 1'b1;
            ch_word = ch_adr_i[k*CAW +: AWW];
            ch_wdat = ch_dat_i[k*32 +: 32];
            ch_wsel = ch_we_i[k];
         end
      end
   end

   assign ch_wr     = ch_any & ch_wsel;
   assign ch_rd_vec = ch_gnt_o & ~ch_we_i;

   // Memory: read-first on both ports; WB lanes are written after the channel word so a
   // same-word collision leaves WB bytes on selected lanes and channel bytes elsewhere.
   always_ff @(posedge wb_clk) begin
      ram_q_a <= mem[wb_ridx];
      ram_q_b <= mem[ch_word];
      if (ch_wr) mem[ch_word] <= ch_wdat;
      if (wb_wr) begin
         for (int n = 0; n < 4; n++) begin
            if (wb_sel_i[n]) mem[wb_ridx][n*8 +: 8] <= wb_dat_i[n*8 +: 8];
         end
      end
   end

   assign wb_rd_masked = ram_q_a & {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

   // First response stage: ack/err, read-lane mask, channel valids and collision flag.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_s1 <= 1'b0;
         err_s1 <= 1'b0;
         sel_q  <= '0;
         vld_s1 <= '0;
         coll_o <= 1'b0;
      end else begin
         ack_s1 <= wb_acc & wb_in_rng;
         err_s1 <= wb_acc & ~wb_in_rng;
         if (wb_acc) sel_q <= wb_sel_i;
         vld_s1 <= ch_rd_vec;
         coll_o <= wb_wr & ch_wr & (wb_ridx == ch_word);
      end
   end

`ifdef WB_DMA_RAM_MCH_OUTREG_EN
   logic                     ack_s2;
   logic                     err_s2;
   logic [NUM_CHANNELS-1:0]  vld_s2;
   logic [MEM_WORD_BITS-1:0] wb_dat_q;
   logic [MEM_WORD_BITS-1:0] ch_dat_q;

   // Output register stage; ch_dat_q only loads alongside a valid so it holds otherwise.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ack_s2   <= 1'b0;
         err_s2   <= 1'b0;
         vld_s2   <= '0;
         wb_dat_q <= '0;
         ch_dat_q <= '0;
      end else begin
         ack_s2   <= ack_s1;
         err_s2   <= err_s1;
         vld_s2   <= vld_s1;
         wb_dat_q <= wb_rd_masked;
         if (|vld_s1) ch_dat_q <= ram_q_b;
      end
   end

   // A response is in flight in the middle cycle; block a second access from the held strobe.
   assign wb_pend  = ack_s1 | err_s1;
   assign wb_ack_o = ack_s2;
   assign wb_err_o = err_s2;
   assign ch_vld_o = vld_s2;
   assign wb_dat_o = wb_dat_q;
   assign ch_dat_o = ch_dat_q;
`else
   logic [MEM_WORD_BITS-1:0] ch_hold;

   // Keep the last delivered channel word so ch_dat_o is stable between valids.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ch_hold <= '0;
      end else if (|vld_s1) begin
         ch_hold <= ram_q_b;
      end
   end

   assign wb_pend  = 1'b0;
   assign wb_ack_o = ack_s1;
   assign wb_err_o = err_s1;
   assign ch_vld_o = vld_s1;
   assign wb_dat_o = wb_rd_masked;
   assign ch_dat_o = (|vld_s1) ? ram_q_b : ch_hold;
`endif

endmodule

// File: tb/tb_wb_dma_ram_mch.sv
// Directed self-checking bench for wb_dma_ram_mch with three channels.
// Expected latency follows WB_DMA_RAM_MCH_OUTREG_EN (1 cycle, or 2 when defined).
// Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns after the edge.
module tb_wb_dma_ram_mch;

   localparam int NC  = 3;
   localparam int AW  = 14;
   localparam int CAW = AW - 2;
`ifdef WB_DMA_RAM_MCH_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              wb_clk;
   logic              wb_rst_n;
   logic [AW-1:0]     wb_adr_i;
   logic [31:0]       wb_dat_i;
   logic [31:0]       wb_dat_o;
   logic              wb_we_i;
   logic [3:0]        wb_sel_i;
   logic              wb_stb_i;
   logic              wb_cyc_i;
   logic              wb_ack_o;
   logic              wb_err_o;
   logic [NC-1:0]     ch_req_i;
   logic [NC-1:0]     ch_we_i;
   logic [NC*CAW-1:0] ch_adr_i;
   logic [NC*32-1:0]  ch_dat_i;
   logic [NC-1:0]     ch_gnt_o;
   logic [NC-1:0]     ch_vld_o;
   logic [31:0]       ch_dat_o;
   logic              coll_o;

   int n_chk  = 0;
   int n_pass = 0;

   wb_dma_ram_mch #(
      .NUM_CHANNELS (NC)
   ) dut (
      .wb_clk   (wb_clk),
      .wb_rst_n (wb_rst_n),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .ch_req_i (ch_req_i),
      .ch_we_i  (ch_we_i),
      .ch_adr_i (ch_adr_i),
      .ch_dat_i (ch_dat_i),
      .ch_gnt_o (ch_gnt_o),
      .ch_vld_o (ch_vld_o),
      .ch_dat_o (ch_dat_o),
      .coll_o   (coll_o)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic set_ch(input int k, input logic req, input logic we,
                         input logic [CAW-1:0] adr, input logic [31:0] dat);
      ch_req_i[k]             = req;
      ch_we_i[k]              = we;
      ch_adr_i[k*CAW +: CAW]  = adr;
      ch_dat_i[k*32 +: 32]    = dat;
   endtask

   // One Wishbone access; entered and left 1 ns after a rising edge. lat=0 means no response.
   task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat, output logic ackd,
                          output logic errd, output logic [31:0] rd);
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      lat = 0; ackd = 1'b0; errd = 1'b0; rd = '0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge wb_clk); #1;
         if (wb_ack_o || wb_err_o) begin
            lat = i; ackd = wb_ack_o; errd = wb_err_o; rd = wb_dat_o;
            break;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(posedge wb_clk); #1;
   endtask

   task automatic test_reset();
      wb_rst_n = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      ch_req_i = '1; ch_we_i = '0; ch_adr_i = '0; ch_dat_i = '0;
      #12;
      n_chk++; if (ch_gnt_o !== 3'b000) $display("FAIL rst_gnt: got %b want 000", ch_gnt_o); else n_pass++;
      n_chk++; if (wb_ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", wb_ack_o); else n_pass++;
      n_chk++; if (wb_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", wb_err_o); else n_pass++;
      n_chk++; if (ch_vld_o !== 3'b000) $display("FAIL rst_vld: got %b want 000", ch_vld_o); else n_pass++;
      n_chk++; if (coll_o !== 1'b0) $display("FAIL rst_coll: got %b want 0", coll_o); else n_pass++;
      n_chk++; if (ch_dat_o !== 32'h0) $display("FAIL rst_chdat: got %h want 00000000", ch_dat_o); else n_pass++;
      ch_req_i = '0;
      @(posedge wb_clk); #1;
      wb_rst_n = 1'b1;
      @(posedge wb_clk); #1;
   endtask

   task automatic test_wb_rw();
      int lat; logic a, e; logic [31:0] rd;
      wb_xfer(1'b1, 14'h0010, 32'hDEAD_BEEF, 4'b1111, lat, a, e, rd);
      n_chk++; if (lat != LAT) $display("FAIL wr_lat: got %0d want %0d", lat, LAT); else n_pass++;
      n_chk++; if (a !== 1'b1) $display("FAIL wr_ack: got %b want 1", a); else n_pass++;
      wb_xfer(1'b0, 14'h0010, 32'h0, 4'b0011, lat, a, e, rd);
      n_chk++; if (lat != LAT) $display("FAIL rd_lat: got %0d want %0d", lat, LAT); else n_pass++;
      n_chk++; if (rd !== 32'h0000_BEEF) $display("FAIL rd_sel0011: got %h want 0000beef", rd); else n_pass++;
      wb_xfer(1'b0, 14'h0010, 32'h0, 4'b1100, lat, a, e, rd);
      n_chk++; if (rd !== 32'hDEAD_0000) $display("FAIL rd_sel1100: got %h want dead0000", rd); else n_pass++;
   endtask

   task automatic test_wb_err();
      int lat; logic a, e; logic [31:0] rd;
      wb_xfer(1'b1, 14'h0000, 32'h1234_5678, 4'b1111, lat, a, e, rd);
      wb_xfer(1'b0, 14'h2000, 32'h0, 4'b1111, lat, a, e, rd);
      n_chk++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else n_pass++;
      n_chk++; if (a !== 1'b0) $display("FAIL oor_rd_ack: got %b want 0", a); else n_pass++;
      n_chk++; if (lat != LAT) $display("FAIL oor_lat: got %0d want %0d", lat, LAT); else n_pass++;
      wb_xfer(1'b1, 14'h2000, 32'hFFFF_FFFF, 4'b1111, lat, a, e, rd);
      n_chk++; if (e !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", e); else n_pass++;
      wb_xfer(1'b0, 14'h0000, 32'h0, 4'b1111, lat, a, e, rd);
      n_chk++; if (rd !== 32'h1234_5678) $display("FAIL oor_nowrite: got %h want 12345678", rd); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [NC-1:0] exp_g [6];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int k = 0; k < NC; k++) set_ch(k, 1'b1, 1'b1, CAW'(12'h200 + k), 32'hC000_0000 + k);
      for (int c = 0; c < 6; c++) begin
         #1;
         n_chk++;
         if (ch_gnt_o !== exp_g[c]) $display("FAIL rr_gnt%0d: got %b want %b", c, ch_gnt_o, exp_g[c]);
         else n_pass++;
         @(posedge wb_clk); #1;
      end
      ch_req_i = '0; ch_we_i = '0;
      @(posedge wb_clk); #1;
   endtask

   task automatic test_ch_read();
      int lat; logic [NC-1:0] v; logic [31:0] d;
      set_ch(2, 1'b1, 1'b0, 12'h202, 32'h0);
      #1;
      n_chk++; if (ch_gnt_o !== 3'b100) $display("FAIL chrd_gnt: got %b want 100", ch_gnt_o); else n_pass++;
      @(posedge wb_clk); #1;
      ch_req_i = '0;
      lat = 0; v = '0; d = '0;
      for (int i = 1; i <= 8; i++) begin
         if (ch_vld_o != '0) begin lat = i; v = ch_vld_o; d = ch_dat_o; break; end
         @(posedge wb_clk); #1;
      end
      n_chk++; if (lat != LAT) $display("FAIL chrd_lat: got %0d want %0d", lat, LAT); else n_pass++;
      n_chk++; if (v !== 3'b100) $display("FAIL chrd_vld: got %b want 100", v); else n_pass++;
      n_chk++; if (d !== 32'hC000_0002) $display("FAIL chrd_dat: got %h want c0000002", d); else n_pass++;
      @(posedge wb_clk); #1;
      n_chk++; if (ch_vld_o !== 3'b000) $display("FAIL chrd_vld_off: got %b want 000", ch_vld_o); else n_pass++;
      n_chk++; if (ch_dat_o !== 32'hC000_0002) $display("FAIL chrd_hold: got %h want c0000002", ch_dat_o); else n_pass++;
   endtask

   task automatic test_wrap();
      int lat; logic a, e; logic [31:0] rd;
      set_ch(0, 1'b1, 1'b1, 12'h805, 32'hA5A5_0001);
      #1;
      n_chk++; if (ch_gnt_o !== 3'b001) $display("FAIL wrap_gnt: got %b want 001", ch_gnt_o); else n_pass++;
      @(posedge wb_clk); #1;
      ch_req_i = '0; ch_we_i = '0;
      wb_xfer(1'b0, 14'h0014, 32'h0, 4'b1111, lat, a, e, rd);
      n_chk++; if (rd !== 32'hA5A5_0001) $display("FAIL wrap_dat: got %h want a5a50001", rd); else n_pass++;
   endtask

   task automatic test_collision();
      int lat; logic a, e; logic [31:0] rd;
      set_ch(1, 1'b1, 1'b1, 12'h030, 32'hAABB_CCDD);
      wb_adr_i = 14'h00C0; wb_dat_i = 32'h1122_3344; wb_sel_i = 4'b0011;
      wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      #1;
      n_chk++; if (ch_gnt_o !== 3'b010) $display("FAIL coll_gnt: got %b want 010", ch_gnt_o); else n_pass++;
      @(posedge wb_clk); #1;
      ch_req_i = '0; ch_we_i = '0;
      n_chk++; if (coll_o !== 1'b1) $display("FAIL coll_pulse: got %b want 1", coll_o); else n_pass++;
      @(posedge wb_clk); #1;
      n_chk++; if (coll_o !== 1'b0) $display("FAIL coll_single: got %b want 0", coll_o); else n_pass++;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge wb_clk); #1; end
      wb_xfer(1'b0, 14'h00C0, 32'h0, 4'b1111, lat, a, e, rd);
      n_chk++; if (rd !== 32'hAABB_3344) $display("FAIL coll_merge: got %h want aabb3344", rd); else n_pass++;
   endtask

   task automatic test_read_first();
      int lat; logic a, e; logic [31:0] rd;
      set_ch(1, 1'b1, 1'b1, 12'h030, 32'h5555_5555);
      wb_adr_i = 14'h00C0; wb_sel_i = 4'b1111; wb_we_i = 1'b0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      @(posedge wb_clk); #1;
      ch_req_i = '0; ch_we_i = '0;
      lat = 0; rd = '0;
      for (int i = 1; i <= 8; i++) begin
         if (wb_ack_o) begin lat = i; rd = wb_dat_o; break; end
         @(posedge wb_clk); #1;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      n_chk++; if (lat != LAT) $display("FAIL rf_lat: got %0d want %0d", lat, LAT); else n_pass++;
      n_chk++; if (rd !== 32'hAABB_3344) $display("FAIL rf_old: got %h want aabb3344", rd); else n_pass++;
      @(posedge wb_clk); #1;
      wb_xfer(1'b0, 14'h00C0, 32'h0, 4'b1111, lat, a, e, rd);
      n_chk++; if (rd !== 32'h5555_5555) $display("FAIL rf_new: got %h want 55555555", rd); else n_pass++;
   endtask

   task automatic test_reset_inflight();
      set_ch(0, 1'b1, 1'b0, 12'h202, 32'h0);
      #1;
      n_chk++; if (ch_gnt_o !== 3'b001) $display("FAIL rif_gnt: got %b want 001", ch_gnt_o); else n_pass++;
      @(posedge wb_clk);
      wb_rst_n = 1'b0;
      ch_req_i = '0;
      #1;
      n_chk++; if (ch_vld_o !== 3'b000) $display("FAIL rif_vld_drop: got %b want 000", ch_vld_o); else n_pass++;
      n_chk++; if (ch_dat_o !== 32'h0) $display("FAIL rif_chdat: got %h want 00000000", ch_dat_o); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         @(posedge wb_clk); #1;
         n_chk++; if (ch_vld_o !== 3'b000) $display("FAIL rif_vld_rst%0d: got %b want 000", i, ch_vld_o); else n_pass++;
      end
      wb_rst_n = 1'b1;
      for (int i = 0; i < LAT + 1; i++) begin
         @(posedge wb_clk); #1;
         n_chk++; if (ch_vld_o !== 3'b000) $display("FAIL rif_vld_post%0d: got %b want 000", i, ch_vld_o); else n_pass++;
      end
      ch_req_i = '1; ch_we_i = '0;
      #1;
      n_chk++; if (ch_gnt_o !== 3'b001) $display("FAIL rif_ptr0: got %b want 001", ch_gnt_o); else n_pass++;
      @(posedge wb_clk); #1;
      ch_req_i = '0;
      for (int i = 0; i < LAT + 1; i++) begin @(posedge wb_clk); #1; end
   endtask

   initial begin
      test_reset();
      test_wb_rw();
      test_wb_err();
      test_round_robin();
      test_ch_read();
      test_wrap();
      test_collision();
      test_read_first();
      test_reset_inflight();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
